led_fade_driver: RTL and testbench

Downstream consumer of the LED blink level: takes the on/off request produced by the blink counter stage and drives the physical LED pin with a PWM waveform. Transitions are ramped linearly in brightness, so the LED fades in and out instead of snapping. It sits between the blink stage and the top-level LED pad.

---
 rtl/led_fade_driver.sv | 85 ++++++++
 tb/tb_led_fade_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// PWM LED driver that ramps brightness linearly between off and full on,
// stepping the level once per PWM period in response to the blink request.
module led_fade_driver #(
  parameter int PWM_BITS = 4,
  parameter int STEP     = 1
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_led,
  output logic                o_pwm,
  output logic [PWM_BITS-1:0] o_level,
  output logic                o_busy,
  output logic                o_period_start
);

  localparam logic [PWM_BITS-1:0] MAX_LVL  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   MAX_EXT  = {1'b0, MAX_LVL};
  localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS+1)'(STEP);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_UP,
    ST_ON,
    ST_DOWN
  } state_t;

  state_t              state_reg, state_next;
  logic [PWM_BITS-1:0] level_reg, level_next;
  logic [PWM_BITS-1:0] cnt_reg;
  logic                period_start_reg;

  logic                wrap;
  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS-1:0] up_level;
  logic [PWM_BITS-1:0] down_level;

  assign wrap = (cnt_reg == MAX_LVL);

  // Saturating step arithmetic, one bit wider than the level so nothing wraps.
  always_comb begin
    up_sum     = {1'b0, level_reg} + STEP_EXT;
    up_level   = (up_sum >= MAX_EXT) ? MAX_LVL : up_sum[PWM_BITS-1:0];
    down_level = ({1'b0, level_reg} <= STEP_EXT) ? '0
               : (level_reg - STEP_EXT[PWM_BITS-1:0]);
  end

  // Request is only looked at on the wrap edge, so duty stays constant within a period.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    if (wrap) begin
      if (i_led) begin
        if (state_reg != ST_ON) begin
          level_next = up_level;
          state_next = (up_level == MAX_LVL) ? ST_ON : ST_UP;
        end
      end else begin
        if (state_reg != ST_OFF) begin
          level_next = down_level;
          state_next = (down_level == '0) ? ST_OFF : ST_DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_reg        <= ST_OFF;
      level_reg        <= '0;
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      level_reg        <= level_next;
      cnt_reg          <= cnt_reg + 1'b1;
      period_start_reg <= wrap;
    end
  end

  assign o_pwm          = (level_reg == MAX_LVL) | (cnt_reg < level_reg);
  assign o_level        = level_reg;
  assign o_busy         = (state_reg == ST_UP) | (state_reg == ST_DOWN);
  assign o_period_start = period_start_reg;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench: two drivers (STEP=1 and STEP=4) share one request; per-period
// expectations are queued by the stimulus and checked at every period start.
module tb_led_fade_driver;

  logic       clk;
  logic       i_reset;
  logic       i_led;
  logic       pwm1, pwm4;
  logic [3:0] lvl1, lvl4;
  logic       busy1, busy4;
  logic       ps1, ps4;

  typedef struct {
    int l1;
    int b1;
    int l4;
    int b4;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  led_fade_driver #(.PWM_BITS(4), .STEP(1)) dut1 (
    .clk(clk), .i_reset(i_reset), .i_led(i_led),
    .o_pwm(pwm1), .o_level(lvl1), .o_busy(busy1), .o_period_start(ps1)
  );

  led_fade_driver #(.PWM_BITS(4), .STEP(4)) dut4 (
    .clk(clk), .i_reset(i_reset), .i_led(i_led),
    .o_pwm(pwm4), .o_level(lvl4), .o_busy(busy4), .o_period_start(ps4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int duty(input int lvl);
    return (lvl == 15) ? 16 : lvl;
  endfunction

  // One PWM period of stimulus starting at a cnt==0 cycle; the pushed entry is
  // what both drivers must show after the wrap edge that ends this period.
  task automatic run_period(input logic led, input int l1, input int b1,
                            input int l4, input int b4, input bit glitch);
    exp_t e;
    i_led = led;
    e.l1 = l1; e.b1 = b1; e.l4 = l4; e.b4 = b4;
    exp_q.push_back(e);
    if (glitch) begin
      repeat (4) @(negedge clk);
      i_led = ~led;
      repeat (3) @(negedge clk);
      i_led = led;
      repeat (9) @(negedge clk);
    end else begin
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_level1", int'(lvl1), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_pwm1", int'(pwm1), 0);
    chk("rst_ps1", int'(ps1), 0);
    chk("rst_level4", int'(lvl4), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_pwm4", int'(pwm4), 0);
    chk("rst_ps4", int'(ps4), 0);
  endtask

  // Monitor: cycle-accurate period_start check, duty count per period,
  // and a scoreboard pop at every period start.
  int cyc = -1;
  int cnt1 = 0, cnt4 = 0;
  int cur1 = 0, cur4 = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        cyc = -1; cnt1 = 0; cnt4 = 0; cur1 = 0; cur4 = 0;
      end else begin
        cyc++;
        chk("period_start1", int'(ps1), int'(cyc > 0 && cyc % 16 == 0));
        chk("period_start4", int'(ps4), int'(cyc > 0 && cyc % 16 == 0));
        if (ps1) begin
          chk("duty1", cnt1, duty(cur1));
          chk("duty4", cnt4, duty(cur4));
          cnt1 = 0; cnt4 = 0;
          if (exp_q.size() == 0) begin
            chk("queue_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] cycle %0d: level1=%0d busy1=%0b level4=%0d busy4=%0b",
                     cyc, lvl1, busy1, lvl4, busy4);
            chk("level1", int'(lvl1), e.l1);
            chk("busy1", int'(busy1), e.b1);
            chk("level4", int'(lvl4), e.l4);
            chk("busy4", int'(busy4), e.b4);
            cur1 = e.l1; cur4 = e.l4;
          end
        end
        cnt1 += int'(pwm1);
        cnt4 += int'(pwm4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b1;
    i_led   = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Idle
    for (int k = 0; k < 4; k++) run_period(1'b0, 0, 0, 0, 0, 1'b0);

    // Fade in: STEP=1 climbs 1..15, STEP=4 goes 4, 8, 12, 15
    for (int k = 1; k <= 15; k++)
      run_period(1'b1, k, int'(k < 15), (4*k > 15) ? 15 : 4*k, int'(4*k < 15), 1'b0);
    run_period(1'b1, 15, 0, 15, 0, 1'b0);

    // Fade out: STEP=4 goes 11, 7, 3, 0
    for (int k = 1; k <= 15; k++)
      run_period(1'b0, 15 - k, int'(k < 15), (15 - 4*k < 0) ? 0 : 15 - 4*k,
                 int'(15 - 4*k > 0), 1'b0);
    run_period(1'b0, 0, 0, 0, 0, 1'b0);

    // Reversals and ignored mid-period pulses
    for (int k = 1; k <= 5; k++)
      run_period(1'b1, k, 1, (4*k > 15) ? 15 : 4*k, int'(4*k < 15), 1'b0);
    run_period(1'b0, 4, 1, 11, 1, 1'b0);
    run_period(1'b1, 5, 1, 15, 0, 1'b0);
    run_period(1'b1, 6, 1, 15, 0, 1'b1);
    run_period(1'b0, 5, 1, 11, 1, 1'b1);
    run_period(1'b1, 6, 1, 15, 0, 1'b0);
    run_period(1'b1, 7, 1, 15, 0, 1'b0);

    // Reset mid-ramp at level 7, request still high
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_state();
    run_period(1'b1, 1, 1, 4, 1, 1'b0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
